histo_stream_rx: RTL and testbench

Receive-side deserializer for the histogram readout link. It samples the two-wire stream (serial clock plus data) produced by the histogram module's serializer and assembles 32-bit words, each carrying an 8-bit zero pad and a 24-bit bin count. It tags every word with its bin index and presents the words on a valid/ready stream with a small FIFO. It sits in the aggregator/bridge FPGA ahead of the host transport and reports frame completion and link errors.

---
 rtl/histo_pkg.sv | 35 +++
 rtl/histo_rx_fifo.sv | 58 +++++
 rtl/histo_stream_rx.sv | 213 +++++++++++++++++++++
 tb/tb_histo_stream_rx.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/histo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : histo_pkg                                                  |
// | Shared widths, receive FSM states and error-bit positions for the    |
// | histogram readout link.                                              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package histo_pkg;

  localparam int HISTO_BINS    = 1024;
  localparam int HISTO_BIN_W   = 10;
  localparam int HISTO_COUNT_W = 24;
  localparam int HISTO_WORD_W  = 32;
  localparam int HISTO_SUM_W   = 34;
  localparam int HISTO_ERR_W   = 3;

  // Positions inside frame_err
  localparam int ERR_PAD = 0;
  localparam int ERR_OVF = 1;
  localparam int ERR_TMO = 2;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_DONE = 2'd2
  } rx_state_e;

  // One FIFO entry: bin index tagged onto the received count
  typedef struct packed {
    logic [HISTO_BIN_W-1:0]   bin;
    logic [HISTO_COUNT_W-1:0] count;
  } histo_entry_t;

endpackage
`default_nettype wire

// File: rtl/histo_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : histo_rx_fifo                                              |
// | First-word-fall-through FIFO of {bin, count} entries. A push while   |
// | full is accepted when a pop happens in the same cycle.               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module histo_rx_fifo
  import histo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  histo_entry_t push_data_i,
  input  logic         pop_i,
  output histo_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  histo_entry_t mem_q [DEPTH];
  logic         w_push;
  logic         w_pop;

  // Extra pointer bit distinguishes full from empty when indices match
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & (~full_o | w_pop);

  // Head reads as zero while empty so the outputs are clean after reset
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/histo_stream_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : histo_stream_rx                                            |
// | Deserializes the histogram readout link (serial clock + data, MSB    |
// | first, 32-bit words), tags each word with its bin index and queues   |
// | it on a valid/ready stream. Reports frame completion and errors.     |
// | Optional: define HISTO_RX_SUM_EN to accumulate the per-frame sum of  |
// | counts on frame_sum; otherwise frame_sum is tied to zero.            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module histo_stream_rx
  import histo_pkg::*;
#(
  parameter int WORDS_PER_FRAME = 1024,
  parameter int FIRST_BIN       = 1023,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_clk_i,
  input  logic                     spi_mosi_i,
  output logic [HISTO_COUNT_W-1:0] word_data,
  output logic [HISTO_BIN_W-1:0]   word_bin,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     frame_done,
  output logic [HISTO_ERR_W-1:0]   frame_err,
  output logic                     frame_abort,
  output logic [HISTO_SUM_W-1:0]   frame_sum
);

  localparam int CNT_W = $clog2(WORDS_PER_FRAME + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  // Serial input capture
  logic [2:0] sclk_sync_q;   // [0],[1] synchronizer, [2] edge-detect history
  logic [1:0] mosi_sync_q;
  logic       edge_q;        // registered rising-edge strobe
  logic       bit_q;         // data bit belonging to edge_q

  // Receive state
  rx_state_e                 state_q;
  logic [4:0]                bit_cnt_q;
  logic [CNT_W-1:0]          word_cnt_q;
  logic [HISTO_BIN_W-1:0]    bin_q;
  logic [HISTO_BIN_W-1:0]    bin_d;
  logic [HISTO_WORD_W-1:0]   shift_q;
  logic [HISTO_WORD_W-1:0]   shift_d;
  logic [TMO_W-1:0]          tmo_q;
  logic [HISTO_ERR_W-1:0]    err_q;

  // Registered status outputs
  logic                      frame_done_q;
  logic                      frame_abort_q;
  logic [HISTO_ERR_W-1:0]    frame_err_q;

  // FIFO interface
  histo_entry_t w_push_entry;
  histo_entry_t w_head;
  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_can_push;
  logic         w_push;
  logic         w_word_done;
  logic         w_tmo_abort;

  assign shift_d = {shift_q[HISTO_WORD_W-2:0], bit_q};
  assign bin_d   = (bin_q == HISTO_BIN_W'(HISTO_BINS - 1)) ? '0 : bin_q + 1'b1;

  // A word completes on the 32nd bit; the timeout fires on a quiet cycle
  assign w_word_done = (state_q == RX_RECV) && edge_q && (bit_cnt_q == 5'd31);
  assign w_tmo_abort = (state_q == RX_RECV) && !edge_q &&
                       (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // A simultaneous pop frees the slot, so a full FIFO still takes the word
  assign w_pop      = word_valid & word_ready;
  assign w_can_push = ~w_full | w_pop;
  assign w_push     = w_word_done & w_can_push;

  assign w_push_entry.bin   = bin_q;
  assign w_push_entry.count = shift_d[HISTO_COUNT_W-1:0];

  histo_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (w_push),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  assign word_valid  = ~w_empty;
  assign word_data   = w_head.count;
  assign word_bin    = w_head.bin;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign frame_err   = frame_err_q;

  // Synchronize the serial pins and register each rising edge with its bit
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      edge_q      <= 1'b0;
      bit_q       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_clk_i};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
      edge_q      <= sclk_sync_q[1] & ~sclk_sync_q[2];
      bit_q       <= mosi_sync_q[1];
    end
  end

  // Receive FSM: word assembly, sticky errors, timeout and frame status
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RX_IDLE;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      bin_q         <= HISTO_BIN_W'(FIRST_BIN);
      shift_q       <= '0;
      tmo_q         <= '0;
      err_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      frame_err_q   <= '0;
    end else begin
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          bit_cnt_q  <= '0;
          word_cnt_q <= '0;
          err_q      <= '0;
          tmo_q      <= '0;
          bin_q      <= HISTO_BIN_W'(FIRST_BIN);
          if (edge_q) begin
            // First edge of a frame carries bit 31 of word 0
            shift_q   <= shift_d;
            bit_cnt_q <= 5'd1;
            state_q   <= RX_RECV;
          end
        end
        RX_RECV: begin
          if (edge_q) begin
            tmo_q   <= '0;
            shift_q <= shift_d;
            if (bit_cnt_q == 5'd31) begin
              bit_cnt_q <= '0;
              if (shift_d[HISTO_WORD_W-1:HISTO_COUNT_W] != '0) err_q[ERR_PAD] <= 1'b1;
              if (!w_can_push) err_q[ERR_OVF] <= 1'b1;
              // Dropped words still consume a bin so later words stay aligned
              bin_q      <= bin_d;
              word_cnt_q <= word_cnt_q + 1'b1;
              if (word_cnt_q == CNT_W'(WORDS_PER_FRAME - 1)) state_q <= RX_DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (w_tmo_abort) begin
            // Partial word discarded; queued words stay in the FIFO
            frame_abort_q        <= 1'b1;
            frame_err_q          <= err_q;
            frame_err_q[ERR_TMO] <= 1'b1;
            state_q              <= RX_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RX_DONE: begin
          // Any serial edge landing here is deliberately ignored
          frame_done_q <= 1'b1;
          frame_err_q  <= err_q;
          state_q      <= RX_IDLE;
        end
        default: begin
          state_q <= RX_IDLE;
        end
      endcase
    end
  end

`ifdef HISTO_RX_SUM_EN
  logic [HISTO_SUM_W-1:0] sum_q;
  logic [HISTO_SUM_W-1:0] frame_sum_q;

  // Accumulate every completed word's count, dropped words included
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q       <= '0;
      frame_sum_q <= '0;
    end else begin
      if (state_q == RX_IDLE) begin
        sum_q <= '0;
      end else if (w_word_done) begin
        sum_q <= sum_q + HISTO_SUM_W'(shift_d[HISTO_COUNT_W-1:0]);
      end
      if ((state_q == RX_DONE) || w_tmo_abort) frame_sum_q <= sum_q;
    end
  end

  assign frame_sum = frame_sum_q;
`else
  assign frame_sum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_histo_stream_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_histo_stream_rx                                         |
// | Directed self-checking bench for histo_stream_rx. Frames are shrunk  |
// | to 16 words; bins start at 1023 and wrap to 0.                       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_histo_stream_rx;

  localparam int WPF = 16;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        spi_clk_i  = 1'b0;
  logic        spi_mosi_i = 1'b0;
  logic        word_ready = 1'b0;
  logic [23:0] word_data;
  logic [9:0]  word_bin;
  logic        word_valid;
  logic        frame_done;
  logic [2:0]  frame_err;
  logic        frame_abort;
  logic [33:0] frame_sum;

  histo_stream_rx #(
    .WORDS_PER_FRAME (WPF),
    .FIRST_BIN       (1023),
    .TIMEOUT_CYCLES  (4096),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_clk_i   (spi_clk_i),
    .spi_mosi_i  (spi_mosi_i),
    .word_data   (word_data),
    .word_bin    (word_bin),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .frame_abort (frame_abort),
    .frame_sum   (frame_sum)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ready_mode = 0;   // 0 low, 1 high, 2 random
  int last_edge_cyc = 0;

  logic [33:0] rx_q[$];
  int          done_cnt  = 0;
  int          abort_cnt = 0;
  logic [2:0]  done_err  = '0;
  logic [33:0] done_sum  = '0;
  logic [2:0]  abort_err = '0;
  int          abort_cyc = 0;

  always @(posedge clk) cyc++;

  // Consumer ready, changed just after each active edge
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       word_ready = 1'b0;
      1:       word_ready = 1'b1;
      default: word_ready = ($urandom_range(0, 99) < 60);
    endcase
  end

  // Observe handshakes and status pulses on the inactive edge
  always @(negedge clk) begin
    if (!reset) begin
      if (word_valid && word_ready) rx_q.push_back({word_bin, word_data});
      if (frame_done) begin
        done_cnt++;
        done_err = frame_err;
        done_sum = frame_sum;
      end
      if (frame_abort) begin
        abort_cnt++;
        abort_err = frame_err;
        abort_cyc = cyc;
      end
    end
  end

  function automatic logic [33:0] exp_entry(input int k);
    int b;
    b = (1023 + k) % 1024;
    return {10'(b), 24'(b * 3)};
  endfunction

  task automatic send_bit(input logic b, input int half);
    spi_mosi_i = b;
    repeat (half) @(posedge clk);
    #1 spi_clk_i = 1'b1;
    last_edge_cyc = cyc;
    repeat (half) @(posedge clk);
    #1 spi_clk_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) send_bit(w[31 - i], half);
  endtask

  task automatic send_frame(input int nwords, input int half, input int pad_idx,
                            input logic [7:0] pad);
    logic [33:0] e;
    for (int k = 0; k < nwords; k++) begin
      e = exp_entry(k);
      send_word({(k == pad_idx) ? pad : 8'h00, e[23:0]}, 32, half);
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s: frame_done count %0d, required %0d (timed out)", name, done_cnt, target);
    end
  endtask

  task automatic check_order(input int n, input string name);
    int bad;
    bad = 0;
    for (int k = 0; k < n && k < rx_q.size(); k++)
      if (rx_q[k] !== exp_entry(k)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d entries out of order, required 0", name, bad);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, want 0", word_valid); end
    checks++; if (word_data !== 24'd0) begin errors++; $display("FAIL rst_data: got %h, want 0", word_data); end
    checks++; if (word_bin !== 10'd0) begin errors++; $display("FAIL rst_bin: got %0d, want 0", word_bin); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, want 0", frame_done); end
    checks++; if (frame_abort !== 1'b0) begin errors++; $display("FAIL rst_abort: got %b, want 0", frame_abort); end
    checks++; if (frame_err !== 3'd0) begin errors++; $display("FAIL rst_err: got %b, want 0", frame_err); end
    checks++; if (frame_sum !== 34'd0) begin errors++; $display("FAIL rst_sum: got %0d, want 0", frame_sum); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_full_frame;
    int base;
    logic [33:0] exp_sum;
    // 3 * (1023 + 0+1+...+14) = 3 * 1128
`ifdef HISTO_RX_SUM_EN
    exp_sum = 34'd3384;
`else
    exp_sum = 34'd0;
`endif
    rx_q.delete();
    base = done_cnt;
    ready_mode = 1;
    send_frame(WPF, 4, -1, 8'h00);
    wait_done(base + 1, 200, "full_done");
    repeat (4) @(negedge clk);
    checks++; if (rx_q.size() != WPF) begin errors++; $display("FAIL full_count: got %0d words, want %0d", rx_q.size(), WPF); end
    checks++; if (rx_q[0] !== {10'd1023, 24'd3069}) begin errors++; $display("FAIL full_first: got %h, want %h", rx_q[0], {10'd1023, 24'd3069}); end
    checks++; if (rx_q[1] !== {10'd0, 24'd0}) begin errors++; $display("FAIL full_second: got %h, want 0", rx_q[1]); end
    check_order(WPF, "full_order");
    checks++; if (done_cnt != base + 1) begin errors++; $display("FAIL full_done_once: got %0d pulses, want 1", done_cnt - base); end
    checks++; if (done_err !== 3'b000) begin errors++; $display("FAIL full_err: got %b, want 000", done_err); end
    checks++; if (done_sum !== exp_sum) begin errors++; $display("FAIL full_sum: got %0d, want %0d", done_sum, exp_sum); end
  endtask

  task automatic test_pad;
    int base;
    rx_q.delete();
    base = done_cnt;
    ready_mode = 1;
    send_frame(WPF, 4, 5, 8'hA5);
    wait_done(base + 1, 200, "pad_done");
    repeat (4) @(negedge clk);
    checks++; if (rx_q.size() != WPF) begin errors++; $display("FAIL pad_count: got %0d, want %0d", rx_q.size(), WPF); end
    // word 5 carries bin 4, count 12
    checks++; if (rx_q[5] !== {10'd4, 24'd12}) begin errors++; $display("FAIL pad_word: got %h, want %h", rx_q[5], {10'd4, 24'd12}); end
    checks++; if (done_err !== 3'b001) begin errors++; $display("FAIL pad_err: got %b, want 001", done_err); end
  endtask

  task automatic test_overflow;
    int base;
    rx_q.delete();
    base = done_cnt;
    ready_mode = 0;
    send_frame(WPF, 4, -1, 8'h00);
    wait_done(base + 1, 200, "ovf_done");
    @(negedge clk);
    checks++; if (done_err !== 3'b010) begin errors++; $display("FAIL ovf_err: got %b, want 010", done_err); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL ovf_leak: got %0d words, want 0", rx_q.size()); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b, want 1", word_valid); end
    ready_mode = 1;
    repeat (12) @(negedge clk);
    checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL ovf_drain: got %0d words, want 4", rx_q.size()); end
    check_order(4, "ovf_order");
  endtask

  task automatic test_timeout;
    int base_d, base_a, t0, n, lat;
    logic [33:0] e;
    rx_q.delete();
    base_d = done_cnt;
    base_a = abort_cnt;
    ready_mode = 1;
    send_frame(10, 4, -1, 8'h00);
    e = exp_entry(10);
    send_word({8'h00, e[23:0]}, 7, 4);
    t0 = last_edge_cyc;
    n = 0;
    while (abort_cnt == base_a && n < 5000) begin
      @(negedge clk);
      n++;
    end
    lat = abort_cyc - t0;
    checks++; if (abort_cnt != base_a + 1) begin errors++; $display("FAIL tmo_abort: got %0d pulses, want 1", abort_cnt - base_a); end
    checks++; if (abort_err !== 3'b100) begin errors++; $display("FAIL tmo_err: got %b, want 100", abort_err); end
    // 3 cycles of sync/edge, 1 to clear the counter, then 4096 quiet cycles
    checks++; if (lat < 4096 || lat > 4104) begin errors++; $display("FAIL tmo_latency: got %0d cycles, want ~4100", lat); end
    checks++; if (done_cnt != base_d) begin errors++; $display("FAIL tmo_nodone: got %0d pulses, want 0", done_cnt - base_d); end
    checks++; if (rx_q.size() != 10) begin errors++; $display("FAIL tmo_words: got %0d, want 10", rx_q.size()); end
    rx_q.delete();
    send_frame(WPF, 4, -1, 8'h00);
    wait_done(base_d + 1, 200, "tmo_next_done");
    repeat (4) @(negedge clk);
    checks++; if (done_err !== 3'b000) begin errors++; $display("FAIL tmo_next_err: got %b, want 000", done_err); end
    check_order(WPF, "tmo_next_order");
  endtask

  task automatic test_reset_mid;
    int base_d, base_a;
    logic [33:0] e;
    rx_q.delete();
    ready_mode = 0;
    send_frame(10, 4, -1, 8'h00);
    e = exp_entry(10);
    send_word({8'h00, e[23:0]}, 13, 4);
    @(negedge clk);
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b, want 1", word_valid); end
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b, want 0", word_valid); end
    checks++; if ({word_bin, word_data} !== 34'd0) begin errors++; $display("FAIL rmid_head: got %h, want 0", {word_bin, word_data}); end
    checks++; if ({frame_done, frame_abort, frame_err} !== 5'd0) begin errors++; $display("FAIL rmid_status: got %b, want 0", {frame_done, frame_abort, frame_err}); end
    @(posedge clk); #1 reset = 1'b0;
    ready_mode = 1;
    repeat (3) @(posedge clk);
    rx_q.delete();
    base_d = done_cnt;
    base_a = abort_cnt;
    send_frame(WPF, 4, -1, 8'h00);
    wait_done(base_d + 1, 200, "rmid_done");
    repeat (4) @(negedge clk);
    checks++; if (rx_q.size() != WPF) begin errors++; $display("FAIL rmid_count: got %0d, want %0d", rx_q.size(), WPF); end
    check_order(WPF, "rmid_order");
    checks++; if (done_err !== 3'b000 || abort_cnt != base_a) begin errors++; $display("FAIL rmid_err: got err %b aborts %0d, want 000 and 0", done_err, abort_cnt - base_a); end
  endtask

  task automatic test_back_to_back;
    int base;
    rx_q.delete();
    base = done_cnt;
    ready_mode = 2;
    send_frame(WPF, 2, -1, 8'h00);
    wait_done(base + 1, 200, "bp_done");
    ready_mode = 1;
    repeat (12) @(negedge clk);
    checks++; if (done_err !== 3'b000) begin errors++; $display("FAIL bp_err: got %b, want 000", done_err); end
    checks++; if (rx_q.size() != WPF) begin errors++; $display("FAIL bp_count: got %0d, want %0d", rx_q.size(), WPF); end
    check_order(WPF, "bp_order");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_pad();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
